toggle_event_rx: RTL and testbench
==================================

// Module: toggle_event_rx
// PURPOSE
//   Receiving end of a toggle-encoded event line: a T flip-flop on the sending
//   side flips its output once per event; this block recovers those events.
//   Synchronises the line, detects each level change and emits a one-cycle
//   pulse per event. Buffers events as a pending count behind a valid/ready
//   consumer handshake and keeps a running event total.
//   Sits between any toggle-line sender and a single-clock consumer FSM.
// PARAMETERS
//   SYNC_STAGES  2   synchroniser depth on t_in, legal >= 2
//   DEPTH        8   max buffered (unconsumed) events, legal >= 1
//   CW           16  width of the running total counter
//   PW (local)   $clog2(DEPTH+1), width of the pending counter
// PORTS
//   clk        in   1    clock, all state updates on posedge
//   rst        in   1    asynchronous, active-high reset
//   t_in       in   1    toggle-encoded event line; each level change = 1 event
//   clr_ovf    in   1    synchronous clear of the overflow flag
//   evt_ready  in   1    consumer accepts one event this cycle
//   evt_valid  out  1    at least one event pending (pending != 0)
//   pulse      out  1    registered one-cycle strobe per detected event
//   pending    out  PW   number of buffered, unconsumed events
//   total      out  CW   detected events since reset, modulo 2^CW
//   overflow   out  1    sticky: an event arrived while the buffer was full
// BEHAVIOUR
//   Reset (async, no clock edge needed): sync stages, delayed copy t_d, pulse,
//     pending, total and overflow all go to 0, so evt_valid = 0. The line
//     idles at 0 from reset; a t_in held at 1 across reset release counts
//     as one event.
//   Sync chain per edge: s[0] <= t_in; s[i] <= s[i-1]; t_d <= s[N-1];
//     pulse <= s[N-1] ^ t_d, where N = SYNC_STAGES.
//   Latency: t_in changes before edge k -> pulse is 1 for exactly the one
//     cycle after edge k+N (3 edges with the default N = 2).
//   Event spacing: t_in toggles must be >= 2 clk periods apart. Closer
//     toggles can be lost and this is not flagged.
//   Event accounting, on each cycle with pulse = 1:
//     - total <= total + 1, wrapping at 2^CW. Dropped events still count.
//     - pending increments unless pending == DEPTH (then see overflow).
//   Pop: evt_valid && evt_ready decrements pending.
//     evt_ready while evt_valid = 0 is ignored; pending never underflows.
//   Push and pop in the same cycle: pending unchanged, even at DEPTH.
//     overflow is not set in that case.
//   Full case: pulse with pending == DEPTH and no pop -> event dropped,
//     pending stays DEPTH, overflow <= 1.
//   overflow stays set until clr_ovf. If clr_ovf and a new overflow occur
//     in the same cycle, the set wins (overflow stays 1).
//   evt_valid is combinational from the pending register (pending != 0).
//     All other outputs are registered.
//   Reset mid-operation drops all buffered events and all sync-stage state.
// TESTING
//   1 rst pulse, t_in = 0 held 20 cycles -> pulse, evt_valid, pending,
//     total, overflow all 0 throughout.
//   2 t_in 0->1 before edge k, evt_ready = 0 -> pulse = 1 only in the cycle
//     after edge k+2; pending = 1, total = 1, evt_valid = 1; then evt_ready
//     = 1 for one cycle -> pending = 0, evt_valid = 0.
//   3 DEPTH = 8, 10 toggles spaced 4 cycles apart, evt_ready = 0 ->
//     pending = 8, overflow sets on the 9th event, total = 10.
//   4 pending = 8, pulse arrives in the same cycle as evt_ready = 1 ->
//     pending stays 8, overflow stays 0.
//   5 overflow = 1: clr_ovf alone -> 0 next cycle; clr_ovf coincident with
//     a full-buffer event -> overflow stays 1.
//   6 CW = 4: 16 events -> total = 0 (wrap). Then assert rst between clock
//     edges with pending = 3 -> all outputs 0 at once, before the next edge.

Source files
------------

// File: rtl/toggle_event_rx.sv
// Toggle-line event receiver: synchronises a T-flop driven line, turns each
// level change into a one-cycle pulse and buffers events behind valid/ready.
module toggle_event_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 8,
  parameter int CW          = 16,
  localparam int PW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          t_in,
  input  logic          clr_ovf,
  input  logic          evt_ready,
  output logic          evt_valid,
  output logic          pulse,
  output logic [PW-1:0] pending,
  output logic [CW-1:0] total,
  output logic          overflow
);

  // Handshake: one event leaves the buffer on every cycle where evt_valid and
  // evt_ready are both high; evt_ready without evt_valid is ignored, and
  // evt_valid depends only on the pending register, never on evt_ready.

  localparam logic [PW-1:0] FULL_LEVEL = PW'(DEPTH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   t_d;
  logic                   line_sync;

  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   ovf_set;
  logic [PW-1:0]          pending_next;

  assign line_sync = sync_q[SYNC_STAGES-1];

  // Stage 0 samples the asynchronous line; the edge detector compares the
  // last synchronised sample with its one-cycle-delayed copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      t_d    <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], t_in};
      t_d    <= line_sync;
      pulse  <= line_sync ^ t_d;
    end
  end

  assign evt_valid = (pending != '0);
  assign push      = pulse;
  assign pop       = evt_valid && evt_ready;
  assign full      = (pending == FULL_LEVEL);

  // A pop in the same cycle frees the slot, so a full buffer only drops an
  // event when nothing leaves.
  always_comb begin
    pending_next = pending;
    ovf_set      = 1'b0;
    if (push && !pop) begin
      if (full) begin
        ovf_set = 1'b1;
      end else begin
        pending_next = pending + PW'(1);
      end
    end else if (!push && pop) begin
      pending_next = pending - PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      total    <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= pending_next;
      if (push) begin
        total <= total + CW'(1);
      end
      // Set has priority over clear so a coincident drop is never lost.
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_toggle_event_rx.sv
// Bench for toggle_event_rx: directed scenarios plus a randomized run checked
// against an event-count model derived from the line's sampled history.
module tb_toggle_event_rx;

  localparam int N     = 2;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int PW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic          t_in;
  logic          clr_ovf;
  logic          evt_ready;
  logic          evt_valid;
  logic          pulse;
  logic [PW-1:0] pending;
  logic [CW-1:0] total;
  logic          overflow;

  int n_tests;
  int n_fail;

  // Reference model state
  bit hist[$];
  bit m_pulse;
  int m_pend;
  int m_total;
  bit m_ovf;

  toggle_event_rx #(
    .SYNC_STAGES(N),
    .DEPTH      (DEPTH),
    .CW         (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .t_in     (t_in),
    .clr_ovf  (clr_ovf),
    .evt_ready(evt_ready),
    .evt_valid(evt_valid),
    .pulse    (pulse),
    .pending  (pending),
    .total    (total),
    .overflow (overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    hist     = '{0, 0, 0};
    m_pulse  = 1'b0;
    m_pend   = 0;
    m_total  = 0;
    m_ovf    = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Advance one edge; the model sees the line sample taken at this edge and
  // the inputs that were stable across it. A level change seen at edge j-N
  // relative to edge j-N-1 shows up as a pulse after edge j.
  task automatic tick();
    bit pop;
    bit drop;
    @(posedge clk);
    hist.push_back(t_in);
    if (hist.size() > 8) void'(hist.pop_front());
    pop  = evt_ready && (m_pend > 0);
    drop = 1'b0;
    if (m_pulse) m_total = (m_total + 1) % (1 << CW);
    if (m_pulse && !pop) begin
      if (m_pend == DEPTH) drop = 1'b1;
      else m_pend = m_pend + 1;
    end else if (!m_pulse && pop) begin
      m_pend = m_pend - 1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    m_pulse = hist[hist.size()-1-N] != hist[hist.size()-2-N];
    #1;
  endtask

  task automatic toggle_and_wait(input int cycles);
    t_in = ~t_in;
    repeat (cycles) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    t_in = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      n_tests++;
      if ({pulse, evt_valid, pending, total, overflow} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: got p=%0b v=%0b pend=%0d tot=%0d ovf=%0b required all 0",
                 i, pulse, evt_valid, pending, total, overflow);
      end
    end
  endtask

  task automatic test_single_event();
    logic [2:0] seen;
    t_in = 1'b0;
    do_reset();
    tick();
    t_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen[i] = pulse;
    end
    n_tests++;
    if (seen !== 3'b100) begin
      n_fail++;
      $display("FAIL single_latency: pulse after edges k..k+2 got %b required 100", seen);
    end
    tick();
    n_tests++;
    if (pulse !== 1'b0 || pending !== PW'(1) || total !== CW'(1) || evt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_accounted: got p=%0b pend=%0d tot=%0d v=%0b required p=0 pend=1 tot=1 v=1",
               pulse, pending, total, evt_valid);
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_tests++;
    if (pending !== '0 || evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pop: got pend=%0d v=%0b required pend=0 v=0", pending, evt_valid);
    end
  endtask

  task automatic test_fill_overflow();
    t_in = 1'b0;
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      toggle_and_wait(4);
      n_tests++;
      if (pending !== PW'((i > DEPTH) ? DEPTH : i) || overflow !== (i > DEPTH)) begin
        n_fail++;
        $display("FAIL fill_event_%0d: got pend=%0d ovf=%0b required pend=%0d ovf=%0b",
                 i, pending, overflow, (i > DEPTH) ? DEPTH : i, (i > DEPTH));
      end
    end
    n_tests++;
    if (total !== CW'(10)) begin
      n_fail++;
      $display("FAIL fill_total: got %0d required 10", total);
    end
  endtask

  task automatic test_full_push_pop();
    t_in = 1'b0;
    do_reset();
    for (int i = 0; i < DEPTH; i++) toggle_and_wait(4);
    t_in = ~t_in;
    repeat (3) tick();
    n_tests++;
    if (pulse !== 1'b1 || pending !== PW'(DEPTH)) begin
      n_fail++;
      $display("FAIL full_setup: got p=%0b pend=%0d required p=1 pend=%0d", pulse, pending, DEPTH);
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_tests++;
    if (pending !== PW'(DEPTH) || overflow !== 1'b0 || total !== CW'(DEPTH + 1)) begin
      n_fail++;
      $display("FAIL full_push_pop: got pend=%0d ovf=%0b tot=%0d required pend=%0d ovf=0 tot=%0d",
               pending, overflow, total, DEPTH, DEPTH + 1);
    end
  endtask

  // Continues from the full buffer left by test_full_push_pop.
  task automatic test_clr_ovf();
    toggle_and_wait(4);
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got %0b required 1", overflow);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %0b required 0", overflow);
    end
    t_in = ~t_in;
    repeat (3) tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_tests++;
    if (overflow !== 1'b1 || pending !== PW'(DEPTH)) begin
      n_fail++;
      $display("FAIL ovf_set_wins: got ovf=%0b pend=%0d required ovf=1 pend=%0d", overflow, pending, DEPTH);
    end
  endtask

  task automatic test_wrap_and_async_reset();
    t_in = 1'b0;
    do_reset();
    evt_ready = 1'b1;
    for (int i = 0; i < 16; i++) toggle_and_wait(2);
    repeat (4) tick();
    n_tests++;
    if (total !== '0 || pending !== '0) begin
      n_fail++;
      $display("FAIL total_wrap: got tot=%0d pend=%0d required tot=0 pend=0", total, pending);
    end
    evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) toggle_and_wait(4);
    n_tests++;
    if (pending !== PW'(3) || total !== CW'(3)) begin
      n_fail++;
      $display("FAIL pre_reset: got pend=%0d tot=%0d required pend=3 tot=3", pending, total);
    end
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if ({pulse, evt_valid, pending, total, overflow} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got p=%0b v=%0b pend=%0d tot=%0d ovf=%0b required all 0",
               pulse, evt_valid, pending, total, overflow);
    end
    do_reset();
  endtask

  task automatic test_random();
    int gap;
    t_in = 1'b0;
    do_reset();
    gap = $urandom_range(2, 5);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (((cyc / 150) % 2) == 0) evt_ready = ($urandom_range(0, 7) == 0);
      else evt_ready = ($urandom_range(0, 1) == 1);
      clr_ovf = ($urandom_range(0, 15) == 0);
      gap = gap - 1;
      if (gap == 0) begin
        t_in = ~t_in;
        gap  = $urandom_range(2, 5);
      end
      tick();
      n_tests++;
      if (pulse !== m_pulse) begin
        n_fail++;
        $display("FAIL rand_pulse cycle %0d: got %0b required %0b", cyc, pulse, m_pulse);
      end
      n_tests++;
      if (pending !== PW'(m_pend) || evt_valid !== (m_pend != 0)) begin
        n_fail++;
        $display("FAIL rand_pending cycle %0d: got pend=%0d v=%0b required pend=%0d",
                 cyc, pending, evt_valid, m_pend);
      end
      n_tests++;
      if (total !== CW'(m_total)) begin
        n_fail++;
        $display("FAIL rand_total cycle %0d: got %0d required %0d", cyc, total, m_total);
      end
      n_tests++;
      if (overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL rand_overflow cycle %0d: got %0b required %0b", cyc, overflow, m_ovf);
      end
    end
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    t_in      = 1'b0;
    clr_ovf   = 1'b0;
    evt_ready = 1'b0;
    model_clear();
    test_reset();
    test_single_event();
    test_fill_overflow();
    test_full_push_pop();
    test_clr_ovf();
    test_wrap_and_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
